// File: rtl/combo_alu_encoder_if.sv
// Bus bundle for the combination encoder: start request, three operand
// digits in, three encoded digits out. Clock and reset stay plain ports.
interface combo_alu_encoder_if;
    logic       LOAD;
    logic [4:0] A;
    logic [4:0] B;
    logic [4:0] C;
    logic [4:0] out0;
    logic [4:0] out1;
    logic [4:0] out2;

    modport master (
        output LOAD, A, B, C,
        input  out0, out1, out2
    );

    modport slave (
        input  LOAD, A, B, C,
        output out0, out1, out2
    );
endinterface

// File: rtl/combo_alu_encoder.sv
// Combination digit encoder. A rising LOAD while idle captures A/B/C, then
// three encode states each produce one term; all three outputs are
// published together on the edge leaving DONE, five edges after the start.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | waiting for a LOAD rising edge; outputs hold last result
//  CAP    | operands captured into ra/rb/rc on the entering edge
//  E0     | t0 = ra + rb (mod 32) registered on the leaving edge
//  E1     | t1 = rotl1(rb ^ rc) registered on the leaving edge
//  E2     | t2 = rc - ra (mod 32) registered on the leaving edge
//  DONE   | out0/out1/out2 load t0/t1/t2 together on the leaving edge
module combo_alu_encoder (
    input  logic                 CLK,
    input  logic                 RST,
    combo_alu_encoder_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CAP  = 3'd1,
        S_E0   = 3'd2,
        S_E1   = 3'd3,
        S_E2   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_load_q;
    logic [4:0] r_ra;
    logic [4:0] r_rb;
    logic [4:0] r_rc;
    logic [4:0] r_t0;
    logic [4:0] r_t1;
    logic [4:0] r_t2;
    logic [4:0] r_out0;
    logic [4:0] r_out1;
    logic [4:0] r_out2;

    logic       w_start;
    logic [4:0] w_bxc;

    // Start only on a fresh LOAD edge while idle; busy-time edges are dropped,
    // and an edge landing on the DONE->IDLE transition is already seen by
    // load_q in IDLE, so it cannot start anything.
    assign w_start = bus.LOAD & ~r_load_q & (r_state == S_IDLE);
    assign w_bxc   = r_rb ^ r_rc;

    assign bus.out0 = r_out0;
    assign bus.out1 = r_out1;
    assign bus.out2 = r_out2;

    // LOAD history for edge detection
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_load_q <= 1'b0;
        end else begin
            r_load_q <= bus.LOAD;
        end
    end

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: fixed one-cycle walk through the encode sequence
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_CAP;
            S_CAP:   w_state_nxt = S_E0;
            S_E0:    w_state_nxt = S_E1;
            S_E1:    w_state_nxt = S_E2;
            S_E2:    w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture; inputs are sampled only on the start edge
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ra <= 5'd0;
            r_rb <= 5'd0;
            r_rc <= 5'd0;
        end else if (w_start) begin
            r_ra <= bus.A;
            r_rb <= bus.B;
            r_rc <= bus.C;
        end
    end

    // Encode terms, one per state; 5-bit wrap discards carry and borrow
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_t0 <= 5'd0;
            r_t1 <= 5'd0;
            r_t2 <= 5'd0;
        end else begin
            if (r_state == S_E0) r_t0 <= r_ra + r_rb;
            if (r_state == S_E1) r_t1 <= {w_bxc[3:0], w_bxc[4]};
            if (r_state == S_E2) r_t2 <= r_rc - r_ra;
        end
    end

    // Publish all three terms at once so no partial result is ever visible
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_out0 <= 5'd0;
            r_out1 <= 5'd0;
            r_out2 <= 5'd0;
        end else if (r_state == S_DONE) begin
            r_out0 <= r_t0;
            r_out1 <= r_t1;
            r_out2 <= r_t2;
        end
    end

endmodule

// File: tb/tb_combo_alu_encoder.sv
// Scoreboard bench for combo_alu_encoder: each start pushes the modelled
// result; the result is popped and compared five edges after the start edge,
// and the outputs are checked to hold their previous value in between.
module tb_combo_alu_encoder;

    typedef struct packed {
        logic [4:0] o0;
        logic [4:0] o1;
        logic [4:0] o2;
    } res_t;

    logic CLK = 1'b0;
    logic RST;

    combo_alu_encoder_if bus ();

    combo_alu_encoder dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    res_t sb_q[$];
    res_t exp_o;
    int   n_cmp = 0;
    int   n_mis = 0;

    function automatic res_t model(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        res_t r;
        int   x;
        r.o0 = 5'((int'(a) + int'(b)) % 32);
        x    = int'(b ^ c);
        r.o1 = 5'(((x * 2) + (x / 16)) % 32);
        r.o2 = 5'((int'(c) - int'(a) + 32) % 32);
        return r;
    endfunction

    // stimulus only: present operands with LOAD high, return after the start edge
    task automatic start_op(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        @(negedge CLK);
        bus.A    = a;
        bus.B    = b;
        bus.C    = c;
        bus.LOAD = 1'b1;
        sb_q.push_back(model(a, b, c));
        @(posedge CLK);
    endtask

    task automatic load_low();
        @(negedge CLK);
        bus.LOAD = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST      = 1'b1;
        bus.LOAD = 1'bx;
        bus.A    = 'x;
        bus.B    = 'x;
        bus.C    = 'x;
        exp_o    = '0;
        #16;
        n_cmp++;
        if ({bus.out0, bus.out1, bus.out2} !== exp_o) begin
            n_mis++;
            $display("FAIL reset_early: got %b %b %b want %b", bus.out0, bus.out1, bus.out2, exp_o);
        end
        #13;
        bus.LOAD = 1'b0;
        bus.A    = '0;
        bus.B    = '0;
        bus.C    = '0;
        #1;
        n_cmp++;
        if ({bus.out0, bus.out1, bus.out2} !== exp_o) begin
            n_mis++;
            $display("FAIL reset_30ns: got %b %b %b want %b", bus.out0, bus.out1, bus.out2, exp_o);
        end
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++;
        if ({bus.out0, bus.out1, bus.out2} !== exp_o) begin
            n_mis++;
            $display("FAIL reset_idle_hold: got %b %b %b want %b", bus.out0, bus.out1, bus.out2, exp_o);
        end
    endtask

    task automatic test_nominal();
        start_op(5'b11110, 5'b00011, 5'b01010);
        for (int k = 1; k <= 5; k++) begin
            @(posedge CLK);
            #1;
            if (k == 5) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_mis++;
                    $display("FAIL nominal_sb_empty: got empty queue want one entry");
                end else exp_o = sb_q.pop_front();
            end
            n_cmp++;
            if ({bus.out0, bus.out1, bus.out2} !== exp_o) begin
                n_mis++;
                $display("FAIL nominal_edge%0d: got %b %b %b want %b", k, bus.out0, bus.out1, bus.out2, exp_o);
            end
        end
        n_cmp++;
        if ({bus.out0, bus.out1, bus.out2} !== 15'b00001_10010_01100) begin
            n_mis++;
            $display("FAIL nominal_literal: got %b %b %b want 00001 10010 01100", bus.out0, bus.out1, bus.out2);
        end
    endtask

    task automatic test_hold_retrigger();
        // LOAD stays high: changed operands must not start anything
        @(negedge CLK);
        bus.A = 5'd1; bus.B = 5'd1; bus.C = 5'd1;
        for (int k = 0; k < 8; k++) begin
            @(posedge CLK);
            #1;
            n_cmp++;
            if ({bus.out0, bus.out1, bus.out2} !== exp_o) begin
                n_mis++;
                $display("FAIL held_load_cycle%0d: got %b %b %b want %b", k, bus.out0, bus.out1, bus.out2, exp_o);
            end
        end
        @(negedge CLK);
        bus.A = 5'b11110; bus.B = 5'b00011; bus.C = 5'b01010;
        bus.LOAD = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            #1;
            n_cmp++;
            if ({bus.out0, bus.out1, bus.out2} !== exp_o) begin
                n_mis++;
                $display("FAIL load_low_cycle%0d: got %b %b %b want %b", k, bus.out0, bus.out1, bus.out2, exp_o);
            end
        end
        start_op(5'b11110, 5'b00011, 5'b01010);
        repeat (4) @(posedge CLK);
        @(posedge CLK);
        #1;
        if (sb_q.size() == 0) begin
            n_cmp++; n_mis++;
            $display("FAIL retrigger_sb_empty: got empty queue want one entry");
        end else exp_o = sb_q.pop_front();
        n_cmp++;
        if ({bus.out0, bus.out1, bus.out2} !== exp_o) begin
            n_mis++;
            $display("FAIL retrigger_result: got %b %b %b want %b", bus.out0, bus.out1, bus.out2, exp_o);
        end
    endtask

    task automatic test_busy_ignore();
        load_low();
        start_op(5'd1, 5'd2, 5'd3);
        for (int k = 1; k <= 5; k++) begin
            @(posedge CLK);
            #1;
            if (k == 5) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_mis++;
                    $display("FAIL busy_sb_empty: got empty queue want one entry");
                end else exp_o = sb_q.pop_front();
            end
            n_cmp++;
            if ({bus.out0, bus.out1, bus.out2} !== exp_o) begin
                n_mis++;
                $display("FAIL busy_edge%0d: got %b %b %b want %b", k, bus.out0, bus.out1, bus.out2, exp_o);
            end
            if (k == 1) begin
                @(negedge CLK);
                bus.A = 5'd31; bus.B = 5'd31; bus.C = 5'd31;
                bus.LOAD = 1'b0;
            end else if (k == 2) begin
                @(negedge CLK);
                bus.LOAD = 1'b1;
            end
        end
        n_cmp++;
        if ({bus.out0, bus.out1, bus.out2} !== 15'b00011_00010_00010) begin
            n_mis++;
            $display("FAIL busy_literal: got %b %b %b want 00011 00010 00010", bus.out0, bus.out1, bus.out2);
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK);
            #1;
            n_cmp++;
            if ({bus.out0, bus.out1, bus.out2} !== exp_o) begin
                n_mis++;
                $display("FAIL busy_no_queue_cycle%0d: got %b %b %b want %b", k, bus.out0, bus.out1, bus.out2, exp_o);
            end
        end
    endtask

    task automatic test_done_edge();
        load_low();
        start_op(5'd4, 5'd5, 5'd6);
        for (int k = 1; k <= 5; k++) begin
            @(posedge CLK);
            #1;
            if (k == 5) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_mis++;
                    $display("FAIL done_edge_sb_empty: got empty queue want one entry");
                end else exp_o = sb_q.pop_front();
            end
            n_cmp++;
            if ({bus.out0, bus.out1, bus.out2} !== exp_o) begin
                n_mis++;
                $display("FAIL done_edge_edge%0d: got %b %b %b want %b", k, bus.out0, bus.out1, bus.out2, exp_o);
            end
            if (k == 1) begin
                @(negedge CLK);
                bus.LOAD = 1'b0;
            end else if (k == 4) begin
                // LOAD rises exactly on the DONE->IDLE edge
                @(negedge CLK);
                bus.A = 5'd20; bus.B = 5'd7; bus.C = 5'd9;
                bus.LOAD = 1'b1;
            end
        end
        for (int k = 0; k < 12; k++) begin
            @(posedge CLK);
            #1;
            n_cmp++;
            if ({bus.out0, bus.out1, bus.out2} !== exp_o) begin
                n_mis++;
                $display("FAIL done_edge_no_start_cycle%0d: got %b %b %b want %b", k, bus.out0, bus.out1, bus.out2, exp_o);
            end
        end
        load_low();
        start_op(5'd20, 5'd7, 5'd9);
        repeat (5) @(posedge CLK);
        #1;
        if (sb_q.size() == 0) begin
            n_cmp++; n_mis++;
            $display("FAIL done_edge_restart_sb_empty: got empty queue want one entry");
        end else exp_o = sb_q.pop_front();
        n_cmp++;
        if ({bus.out0, bus.out1, bus.out2} !== exp_o) begin
            n_mis++;
            $display("FAIL done_edge_restart: got %b %b %b want %b", bus.out0, bus.out1, bus.out2, exp_o);
        end
    endtask

    task automatic test_wrap();
        load_low();
        start_op(5'd31, 5'd1, 5'd0);
        repeat (4) @(posedge CLK);
        #1;
        n_cmp++;
        if ({bus.out0, bus.out1, bus.out2} !== exp_o) begin
            n_mis++;
            $display("FAIL wrap_edge4_partial: got %b %b %b want %b", bus.out0, bus.out1, bus.out2, exp_o);
        end
        @(posedge CLK);
        #1;
        if (sb_q.size() == 0) begin
            n_cmp++; n_mis++;
            $display("FAIL wrap_sb_empty: got empty queue want one entry");
        end else exp_o = sb_q.pop_front();
        n_cmp++;
        if ({bus.out0, bus.out1, bus.out2} !== 15'b00000_00010_00001) begin
            n_mis++;
            $display("FAIL wrap_result: got %b %b %b want 00000 00010 00001", bus.out0, bus.out1, bus.out2);
        end
    endtask

    task automatic test_mid_reset();
        load_low();
        start_op(5'd5, 5'd9, 5'd20);
        repeat (2) @(posedge CLK);
        // now in E1
        #2;
        RST = 1'b1;
        #1;
        sb_q.delete();
        exp_o = '0;
        n_cmp++;
        if ({bus.out0, bus.out1, bus.out2} !== exp_o) begin
            n_mis++;
            $display("FAIL mid_reset_immediate: got %b %b %b want %b", bus.out0, bus.out1, bus.out2, exp_o);
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        bus.A = 5'd7; bus.B = 5'd12; bus.C = 5'd3;
        sb_q.push_back(model(5'd7, 5'd12, 5'd3));
        RST = 1'b0;
        @(posedge CLK);
        for (int k = 1; k <= 5; k++) begin
            @(posedge CLK);
            #1;
            if (k == 5) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_mis++;
                    $display("FAIL mid_reset_sb_empty: got empty queue want one entry");
                end else exp_o = sb_q.pop_front();
            end
            n_cmp++;
            if ({bus.out0, bus.out1, bus.out2} !== exp_o) begin
                n_mis++;
                $display("FAIL mid_reset_restart_edge%0d: got %b %b %b want %b", k, bus.out0, bus.out1, bus.out2, exp_o);
            end
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK);
            #1;
            n_cmp++;
            if ({bus.out0, bus.out1, bus.out2} !== exp_o) begin
                n_mis++;
                $display("FAIL mid_reset_single_op_cycle%0d: got %b %b %b want %b", k, bus.out0, bus.out1, bus.out2, exp_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_hold_retrigger();
        test_busy_ignore();
        test_done_edge();
        test_wrap();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/combo_alu_encoder.md
COMBO_ALU_ENCODER -- requirements
Module: combo_alu

Interface
REQ-001: The block SHALL run on one clock and use an asynchronous, active-high reset; the clock and reset ports SHALL be named CLK and RST.
REQ-002: CLK  input  1  system clock; all state SHALL update on its rising edge.
REQ-003: RST  input  1  asynchronous reset, active-high; clears all state immediately, independent of CLK.
REQ-004: LOAD  input  1  start request; a rising edge of LOAD starts one encode operation.
REQ-005: A  input  5  combination digit 0, unsigned.
REQ-006: B  input  5  combination digit 1, unsigned.
REQ-007: C  input  5  combination digit 2, unsigned.
REQ-008: out0  output  5  encoded digit 0, registered.
REQ-009: out1  output  5  encoded digit 1, registered.
REQ-010: out2  output  5  encoded digit 2, registered.

Function
REQ-011: The block SHALL register LOAD every cycle into load_q. A start SHALL be detected at a rising CLK edge where LOAD=1, load_q=0 and the FSM is in IDLE.
REQ-012: The FSM SHALL have the states IDLE, CAP, E0, E1, E2 and DONE.
- IDLE: goes to CAP on a start.
- CAP, E0, E1, E2: each lasts exactly one cycle, then goes to the next state in that order.
- DONE: goes to IDLE after one cycle.
REQ-013: At the start edge, the block SHALL capture A, B and C into internal registers ra, rb and rc. The inputs SHALL NOT be sampled at any other time.
REQ-014: In E0, the block SHALL compute t0 = (ra + rb) mod 32, with the carry discarded.
REQ-015: In E1, the block SHALL compute t1 = rotate-left-by-1(rb XOR rc) over 5 bits, so bit4 moves to bit0.
REQ-016: In E2, the block SHALL compute t2 = (rc - ra) mod 32, two's-complement wrap with the borrow discarded.
REQ-017: On the edge that leaves DONE, out0, out1 and out2 SHALL load t0, t1 and t2 simultaneously.
- The outputs SHALL never show partial results.
- Latency: the outputs SHALL update 5 rising edges after the start edge.
REQ-018: The outputs SHALL hold their last values between operations.
REQ-019: Changes on A, B, C or LOAD while the FSM is not in IDLE SHALL be ignored. A LOAD rising edge during busy SHALL NOT be queued.
REQ-020: LOAD held high continuously SHALL produce exactly one operation. Another operation SHALL require LOAD to go low and then high again.
REQ-021: A LOAD rising edge that coincides with the FSM returning to IDLE SHALL NOT start an operation. The next edge with LOAD=1 and load_q=0 while in IDLE SHALL start one.
REQ-022: Arithmetic SHALL be unsigned 5-bit with no saturation and no error flags.

Reset
REQ-023: While RST=1, the following SHALL hold:
- The FSM SHALL be in IDLE.
- load_q SHALL be 0.
- ra, rb, rc, t0, t1 and t2 SHALL be 0.
- out0, out1 and out2 SHALL be 5'b00000.
REQ-024: A reset asserted mid-operation SHALL abort the operation and leave the outputs at 0.
REQ-025: When LOAD is already high at the first edge after reset release, this SHALL count as a rising edge and start an operation.
REQ-026: Unknown (X) values on LOAD during reset SHALL have no effect.

Verification
REQ-027: Reset: RST=1 for 30 ns, with LOAD/A/B/C unknown -> out0=out1=out2=0 and FSM in IDLE.
REQ-028: Nominal: after reset, A=11110, B=00011, C=01010, LOAD rises and stays high -> 5 edges after the start edge, out0=00001, out1=10010, out2=01100.
REQ-029: Hold and retrigger: drop LOAD for 3 cycles, then raise it again with the same inputs -> no output change while LOAD is low; after the retrigger the outputs stay 00001, 10010, 01100.
REQ-030: Busy ignore:
- Start with A=1, B=2, C=3.
- During E0, change to A=31, B=31, C=31 and toggle LOAD.
- Required response: exactly one operation; out0=00011, out1=00010, out2=00010.
REQ-031: Wrap: A=31, B=1, C=0 -> out0=00000, out1=00010, out2=00001.
REQ-032: Mid-operation reset: assert RST during E1 -> outputs immediately 0. After release with LOAD still high, one new operation runs.
